// File: rtl/bram_fifo_ctrl_if.sv
// Handshake and BRAM-port bundle for bram_fifo_ctrl; almost_full exists only when
// BRAM_FIFO_ALMOST_FULL_EN is defined.
interface bram_fifo_ctrl_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [9:0]  level;
    logic [7:0]  bram_wr_addr;
    logic [31:0] bram_wr_data;
    logic [7:0]  bram_rd_addr;
    logic [31:0] bram_rd_data;
`ifdef BRAM_FIFO_ALMOST_FULL_EN
    logic        almost_full;
`endif

    modport slave (
        input  s_data, s_valid, m_ready, bram_rd_data,
        output s_ready, m_data, m_valid, level,
        output bram_wr_addr, bram_wr_data, bram_rd_addr
`ifdef BRAM_FIFO_ALMOST_FULL_EN
        , output almost_full
`endif
    );

    modport master (
        output s_data, s_valid, m_ready, bram_rd_data,
        input  s_ready, m_data, m_valid, level,
        input  bram_wr_addr, bram_wr_data, bram_rd_addr
`ifdef BRAM_FIFO_ALMOST_FULL_EN
        , input almost_full
`endif
    );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// 512x16 FIFO controller around a 1KB BRAM tile with a 2-entry output skid buffer.
// Optional registered almost_full output enabled by BRAM_FIFO_ALMOST_FULL_EN.
module bram_fifo_ctrl #(
    parameter int WR_ADDR_MSB_BIT    = 16,
    parameter int WR_EN_BIT          = 20,
    parameter int RD_SEL_BIT         = 24,
    parameter int ALMOST_FULL_THRESH = 480
) (
    input  logic            clk,
    input  logic            resetn,
    bram_fifo_ctrl_if.slave bus
);
    localparam logic [9:0] DEPTH = 10'd512;

    logic [8:0]  wptr_q, wptr_d;
    logic [8:0]  rptr_q, rptr_d;
    logic [9:0]  mem_cnt_q, mem_cnt_d;
    logic [9:0]  level_q, level_d;
    logic        in_flight_q, in_flight_d;
    logic [1:0]  ob_cnt_q, ob_cnt_d;
    logic [15:0] ob0_q, ob0_d;
    logic [15:0] ob1_q, ob1_d;
    logic        s_ready_q, s_ready_d;

    logic        push;
    logic        pop;
    logic        issue;
    logic [1:0]  occ_after_pop;
    logic [1:0]  ob_slot;
    logic [15:0] rd_word;
    logic [31:0] wr_data;
    logic        unused_rd_hi;

    assign rd_word      = bus.bram_rd_data[15:0];
    assign unused_rd_hi = ^bus.bram_rd_data[31:16];

    always_comb begin
        push = bus.s_valid && s_ready_q;
        pop  = (ob_cnt_q != 2'd0) && bus.m_ready;

        // A pop this cycle frees a skid slot; counting it sustains one word per cycle.
        occ_after_pop = ob_cnt_q + {1'b0, in_flight_q} - {1'b0, pop};
        issue         = (mem_cnt_q != 10'd0) && (occ_after_pop < 2'd2);

        wptr_d      = wptr_q + {8'd0, push};
        rptr_d      = rptr_q + {8'd0, issue};
        mem_cnt_d   = mem_cnt_q + {9'd0, push} - {9'd0, issue};
        in_flight_d = issue;
        ob_cnt_d    = occ_after_pop;

        ob_slot = ob_cnt_q - {1'b0, pop};
        ob0_d   = ob0_q;
        ob1_d   = ob1_q;
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (in_flight_q) begin
            if (ob_slot == 2'd0) begin
                ob0_d = rd_word;
            end else begin
                ob1_d = rd_word;
            end
        end

        level_d   = mem_cnt_d + {9'd0, in_flight_d} + {8'd0, ob_cnt_d};
        s_ready_d = (mem_cnt_d < DEPTH);
    end

    always_comb begin
        wr_data             = '0;
        wr_data[RD_SEL_BIT] = rptr_q[8];
        if (push) begin
            wr_data[15:0]           = bus.s_data;
            wr_data[WR_ADDR_MSB_BIT] = wptr_q[8];
            wr_data[WR_EN_BIT]      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_cnt_q   <= '0;
            level_q     <= '0;
            in_flight_q <= 1'b0;
            ob_cnt_q    <= '0;
            ob0_q       <= '0;
            ob1_q       <= '0;
            s_ready_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_cnt_q   <= mem_cnt_d;
            level_q     <= level_d;
            in_flight_q <= in_flight_d;
            ob_cnt_q    <= ob_cnt_d;
            ob0_q       <= ob0_d;
            ob1_q       <= ob1_d;
            s_ready_q   <= s_ready_d;
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.m_data       = ob0_q;
    assign bus.m_valid      = (ob_cnt_q != 2'd0);
    assign bus.level        = level_q;
    assign bus.bram_wr_addr = wptr_q[7:0];
    assign bus.bram_rd_addr = rptr_q[7:0];
    assign bus.bram_wr_data = wr_data;

`ifdef BRAM_FIFO_ALMOST_FULL_EN
    logic af_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (mem_cnt_d >= 10'(ALMOST_FULL_THRESH));
        end
    end

    assign bus.almost_full = af_q;
`else
    localparam int af_thresh_unused = ALMOST_FULL_THRESH;
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl: behavioural BRAM, word-order queue and
// held-word count model; almost_full checks compile in with BRAM_FIFO_ALMOST_FULL_EN.
module tb_bram_fifo_ctrl;
    localparam int          WA_BIT  = 16;
    localparam int          WE_BIT  = 20;
    localparam int          RS_BIT  = 24;
    localparam logic [31:0] RS_MASK = ~(32'd1 << RS_BIT);

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb_q[$];
    int          n_push = 0;
    int          n_pop  = 0;
    bit          hold_prev = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] bram [0:511];
    logic [15:0] next_val;
    bit          acc;
    bit          popd;
    int          cnt;
    int          guard;

    always #5 clk = ~clk;

    bram_fifo_ctrl_if bus ();

    bram_fifo_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // 512x16 BRAM: address {half, row}, one-cycle registered read, junk in upper bits.
    always @(posedge clk) begin
        if (bus.bram_wr_data[WE_BIT])
            bram[{bus.bram_wr_data[WA_BIT], bus.bram_wr_addr}] <= bus.bram_wr_data[15:0];
        bus.bram_rd_data <= {16'($urandom), bram[{bus.bram_wr_data[RS_BIT], bus.bram_rd_addr}]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: words held = accepted - popped; pushes enqueue, pops dequeue and compare.
    always @(negedge clk) begin
        if (!resetn) begin
            sb_q.delete();
            n_push    = 0;
            n_pop     = 0;
            hold_prev = 1'b0;
        end else begin
            check("level", {22'd0, bus.level}, 32'(n_push - n_pop));
            if (hold_prev) begin
                check("hold_valid", {31'd0, bus.m_valid}, 32'd1);
                check("hold_data", {16'd0, bus.m_data}, {16'd0, held});
            end
            if (bus.s_valid && bus.s_ready) begin
                check("wr_data", bus.bram_wr_data & RS_MASK,
                      (32'd1 << WE_BIT) | (32'((n_push >> 8) & 1) << WA_BIT) | {16'd0, bus.s_data});
                check("wr_addr", {24'd0, bus.bram_wr_addr}, 32'(n_push & 255));
                sb_q.push_back(bus.s_data);
                n_push++;
            end else begin
                check("wr_idle", bus.bram_wr_data & RS_MASK, 32'd0);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow: got 0x%0h, expected no pop at %0t", bus.m_data, $time);
                end else begin
                    check("m_data", {16'd0, bus.m_data}, {16'd0, sb_q.pop_front()});
                end
                n_pop++;
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            held      = bus.m_data;
        end
    end

    task automatic cyc(output bit a, output bit p);
        @(negedge clk);
        a = bus.s_valid && bus.s_ready;
        p = bus.m_valid && bus.m_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc(acc, popd);
        if (acc) begin
            next_val++;
            bus.s_data = next_val;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        next_val    = 16'h0100;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rst_m_data", {16'd0, bus.m_data}, 32'd0);
        check("rst_level", {22'd0, bus.level}, 32'd0);
        check("rst_wr_data", bus.bram_wr_data, 32'd0);
        check("rst_wr_addr", {24'd0, bus.bram_wr_addr}, 32'd0);
        check("rst_rd_addr", {24'd0, bus.bram_rd_addr}, 32'd0);
`ifdef BRAM_FIFO_ALMOST_FULL_EN
        check("rst_almost_full", {31'd0, bus.almost_full}, 32'd0);
`endif
        resetn = 1'b1;
        #1;
        check("s_ready_before_edge", {31'd0, bus.s_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("s_ready_after_release", {31'd0, bus.s_ready}, 32'd1);

        // Single word through an empty FIFO
        bus.s_data  = 16'h1234;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check("wr_data_first", bus.bram_wr_data, 32'h0010_1234);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        cnt = 1;
        while (!bus.m_valid && cnt < 6) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("first_latency_le3", 32'(cnt <= 3), 32'd1);
        check("first_m_data", {16'd0, bus.m_data}, 32'h1234);
        repeat (3) @(posedge clk);
        #1;
        check("level_after_single", {22'd0, bus.level}, 32'd0);

        // Fill with no pops: 512 in memory plus 2 prefetched into the skid buffer
        bus.m_ready = 1'b0;
        bus.s_data  = next_val;
        bus.s_valid = 1'b1;
        cnt   = 0;
        guard = 0;
        while (bus.s_ready && guard < 700) begin
            cyc(acc, popd);
            guard++;
            if (acc) begin
                cnt++;
                next_val++;
                bus.s_data = next_val;
            end
        end
        check("fill_accepts", 32'(cnt), 32'd514);
        check("fill_level", {22'd0, bus.level}, 32'd514);
        check("fill_s_ready", {31'd0, bus.s_ready}, 32'd0);
        repeat (8) begin
            bus.s_data = 16'($urandom);
            cyc(acc, popd);
        end
        check("ignored_push_level", {22'd0, bus.level}, 32'd514);
        bus.s_data  = next_val;
        bus.s_valid = 1'b0;

`ifdef BRAM_FIFO_ALMOST_FULL_EN
        check("af_full", {31'd0, bus.almost_full}, 32'd1);
        guard = 0;
        while ((n_push - n_pop - 2) > 475 && guard < 60) begin
            bus.m_ready = 1'b1;
            step();
            bus.m_ready = 1'b0;
            repeat (4) step();
            check("af_drain", {31'd0, bus.almost_full}, 32'((n_push - n_pop - 2) >= 480));
            guard++;
        end
        repeat (6) begin
            bus.s_valid = 1'b1;
            step();
            bus.s_valid = 1'b0;
            repeat (3) step();
            check("af_fill", {31'd0, bus.almost_full}, 32'((n_push - n_pop - 2) >= 480));
        end
`endif

        // Refill, then stream with steady m_ready for 1000 cycles
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b0;
        guard = 0;
        while (bus.s_ready && guard < 700) begin
            step();
            guard++;
        end
        check("refill_level", {22'd0, bus.level}, 32'd514);
        bus.m_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (popd) cnt++;
        end
        check("stream_pops", 32'(cnt), 32'd1000);

        // Random back-pressure with continuous pushes
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            step();
            if (popd) cnt++;
        end
        check("random_pops_min", 32'(cnt >= 300), 32'd1);

        // Drain
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        guard = 0;
        while (bus.level != 10'd0 && guard < 700) begin
            step();
            guard++;
        end
        check("drain_level", {22'd0, bus.level}, 32'd0);

        // Reset with words stored and a read in flight
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        cnt   = 0;
        guard = 0;
        while (cnt < 10 && guard < 50) begin
            step();
            guard++;
            if (acc) cnt++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        resetn      = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("midrst_level", {22'd0, bus.level}, 32'd0);
        check("midrst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus.s_data  = 16'hBEEF;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        cnt = 0;
        while (!bus.m_valid && cnt < 8) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("post_reset_first", {16'd0, bus.m_data}, 32'hBEEF);
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_level", {22'd0, bus.level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
